// File: rtl/rs232_tx_serialiser_pkg.sv
// -----------------------------------------------------------------------------
// rs232_tx_serialiser_pkg
//   Shared definitions for the RS-232 transmit serialiser:
//   - tx_state_e : transmit FSM state encoding
//   - DATA_BITS, START_LEVEL, STOP_LEVEL : 8N1 framing constants
//   - clog2      : ceiling log2, usable in constant expressions
// -----------------------------------------------------------------------------
package rs232_tx_serialiser_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  localparam int   DATA_BITS   = 8;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

  // Smallest n with 2**n >= value; returns 0 for value <= 1.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/rs232_tx_serialiser_if.sv
// -----------------------------------------------------------------------------
// rs232_tx_serialiser_if
//   32-bit stb/ack word stream feeding the serialiser.
//   input_in      : data word (only [7:0] is transmitted)
//   input_in_stb  : source has a valid word, held until ack is seen
//   input_in_ack  : one-cycle pulse, word captured
//   master modport: the word source; slave modport: the serialiser.
// -----------------------------------------------------------------------------
interface rs232_tx_serialiser_if;

  logic [31:0] input_in;
  logic        input_in_stb;
  logic        input_in_ack;

  modport master (
    output input_in,
    output input_in_stb,
    input  input_in_ack
  );

  modport slave (
    input  input_in,
    input  input_in_stb,
    output input_in_ack
  );

endinterface

// File: rtl/rs232_tx_serialiser_fifo.sv
// -----------------------------------------------------------------------------
// rs232_tx_fifo
//   Synchronous circular-buffer FIFO.
//   Pointers carry one extra wrap bit so that full and empty are told apart
//   without a separate occupancy counter.
// Ports:
//   clk   in  clock, rising edge
//   rst   in  asynchronous reset, active-low (empties the FIFO)
//   push  in  write din this cycle (ignored when full)
//   din   in  WIDTH-bit write data
//   pop   in  advance the read pointer this cycle (ignored when empty)
//   dout  out WIDTH-bit head-of-queue data (valid when !empty)
//   full  out DEPTH entries held
//   empty out no entries held
// -----------------------------------------------------------------------------
module rs232_tx_fifo
  import rs232_tx_serialiser_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  // Wrap bits differ but slot indices match: writer is a whole lap ahead.
  assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                 (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign empty = (r_wr_ptr == r_rd_ptr);
  assign dout  = r_mem[r_rd_ptr[AW-1:0]];

  // Pointers wrap naturally modulo 2*DEPTH through the extra bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
      end
    end
  end

  // Storage carries no reset; stale slots are never read while empty.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/rs232_tx_serialiser.sv
// -----------------------------------------------------------------------------
// rs232_tx_serialiser
//   Consumes a 32-bit stb/ack word stream, buffers bits [7:0] of each word in
//   a FIFO and transmits them as 8N1 asynchronous serial frames.
// Parameters:
//   CLOCK_FREQUENCY  clk frequency in Hz
//   BAUD_RATE        line rate; CLOCKS_PER_BIT = CLOCK_FREQUENCY/BAUD_RATE (>=2)
//   FIFO_DEPTH       byte buffer entries (power of 2, >=2)
// Ports:
//   clk   in   single clock, rising edge
//   rst   in   asynchronous reset, active-low
//   s_in  slave word stream (input_in, input_in_stb, input_in_ack)
//   tx    out  serial line, idle high
//   busy  out  high while a frame is in flight or bytes are queued
// -----------------------------------------------------------------------------
module rs232_tx_serialiser
  import rs232_tx_serialiser_pkg::*;
#(
  parameter int CLOCK_FREQUENCY = 100000000,
  parameter int BAUD_RATE       = 115200,
  parameter int FIFO_DEPTH      = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  rs232_tx_serialiser_if.slave        s_in,
  output logic                        tx,
  output logic                        busy
);

  localparam int CLOCKS_PER_BIT = CLOCK_FREQUENCY / BAUD_RATE;
  localparam int CNT_W          = (clog2(CLOCKS_PER_BIT) < 1) ? 1 : clog2(CLOCKS_PER_BIT);
  localparam int IDX_W          = clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLOCKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

  // Line level implied by the FSM position; sampled into the tx register.
  function automatic logic line_level(input tx_state_e state, input logic data_bit);
    logic level;
    level = STOP_LEVEL;
    case (state)
      START:   level = START_LEVEL;
      DATA:    level = data_bit;
      default: level = STOP_LEVEL;
    endcase
    return level;
  endfunction

  tx_state_e            r_state;
  logic [CNT_W-1:0]     r_baud_cnt;
  logic [IDX_W-1:0]     r_bit_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_tx;
  logic                 r_busy;
  logic                 r_ack;

  logic                 w_accept;
  logic                 w_pop;
  logic                 w_tick;
  logic                 w_full;
  logic                 w_empty;
  logic [DATA_BITS-1:0] w_fifo_dout;
  logic [23:0]          w_unused_upper;

  // Upper word bits are intentionally dropped.
  assign w_unused_upper = s_in.input_in[31:8];

  // ---------------------------------------------------------------------------
  // Input handshake
  // ---------------------------------------------------------------------------
  // Refusing to accept while ack is high keeps a single stb assertion from
  // being captured twice while the source is still reacting to the ack.
  assign w_accept = s_in.input_in_stb && !r_ack && !w_full;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ack <= 1'b0;
    end else begin
      r_ack <= w_accept;
    end
  end

  assign s_in.input_in_ack = r_ack;

  // ---------------------------------------------------------------------------
  // Byte buffer
  // ---------------------------------------------------------------------------
  assign w_pop = (r_state == IDLE) && !w_empty;

  rs232_tx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_accept),
    .din   (s_in.input_in[DATA_BITS-1:0]),
    .pop   (w_pop),
    .dout  (w_fifo_dout),
    .full  (w_full),
    .empty (w_empty)
  );

  // ---------------------------------------------------------------------------
  // Baud timing and transmit FSM
  // ---------------------------------------------------------------------------
  assign w_tick = (r_baud_cnt == BAUD_LAST);

  // tx and busy are registered images of the FSM one cycle behind it, so the
  // line falls two cycles after the ack pulse when the FIFO was empty, and
  // the async reset forces the idle level straight onto the pin.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_baud_cnt <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_tx       <= STOP_LEVEL;
      r_busy     <= 1'b0;
    end else begin
      r_tx   <= line_level(r_state, r_shift[0]);
      r_busy <= (r_state != IDLE) || !w_empty;

      case (r_state)
        IDLE: begin
          if (!w_empty) begin
            r_shift    <= w_fifo_dout;
            r_baud_cnt <= '0;
            r_state    <= START;
          end
        end

        START: begin
          if (w_tick) begin
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            r_state    <= DATA;
          end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
          end
        end

        DATA: begin
          if (w_tick) begin
            r_baud_cnt <= '0;
            r_shift    <= {1'b0, r_shift[DATA_BITS-1:1]};
            if (r_bit_idx == IDX_LAST) begin
              r_state <= STOP;
            end else begin
              r_bit_idx <= r_bit_idx + 1'b1;
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
          end
        end

        STOP: begin
          if (w_tick) begin
            r_baud_cnt <= '0;
            r_state    <= IDLE;
          end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
          end
        end

        default: begin
          r_baud_cnt <= '0;
          r_state    <= IDLE;
        end
      endcase
    end
  end

  assign tx   = r_tx;
  assign busy = r_busy;

endmodule
